// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I size/sign codes and FSM states.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2,
        ERR  = 2'd3
    } lsu_state_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: byte enables, replicated store data, legality check,
// and extraction/extension of the load lane from the bus read word.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic        i_we,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_wdata,
    input  logic [2:0]  i_ld_funct3,
    input  logic [1:0]  i_ld_off,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic        o_bad,
    output logic [31:0] o_ld_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Request side: enables, store replication, misalignment and illegal encodings
    always_comb begin
        o_be    = 4'b0000;
        o_wdata = 32'h0000_0000;
        o_bad   = 1'b0;
        case (i_funct3)
            F3_B, F3_BU: begin
                o_be    = 4'b0001 << i_off;
                o_wdata = {4{i_wdata[7:0]}};
                o_bad   = (i_funct3 == F3_BU) & i_we;
            end
            F3_H, F3_HU: begin
                o_be    = i_off[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_wdata[15:0]}};
                o_bad   = i_off[0] | ((i_funct3 == F3_HU) & i_we);
            end
            F3_W: begin
                o_be    = 4'b1111;
                o_wdata = i_wdata;
                o_bad   = |i_off;
            end
            default: begin
                o_bad   = 1'b1;
            end
        endcase
    end

    // Lane selection from the captured byte offset
    always_comb begin
        w_byte = 8'h00;
        case (i_ld_off)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            2'd3:    w_byte = i_rdata[31:24];
            default: w_byte = 8'h00;
        endcase
        if (i_ld_off[1]) begin
            w_half = i_rdata[31:16];
        end else begin
            w_half = i_rdata[15:0];
        end
    end

    // Sign or zero extension according to the captured size/sign code
    always_comb begin
        o_ld_data = 32'h0000_0000;
        case (i_ld_funct3)
            F3_B:    o_ld_data = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_ld_data = {24'h00_0000, w_byte};
            F3_H:    o_ld_data = {{16{w_half[15]}}, w_half};
            F3_HU:   o_ld_data = {16'h0000, w_half};
            F3_W:    o_ld_data = i_rdata;
            default: o_ld_data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit behind the ALU: drives a word-wide req/ack memory bus, stalls the core
// while a transaction is outstanding, and returns extended load data or an error pulse.
module lsu_mem_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lsu_valid,
    input  logic        lsu_we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] lsu_rdata,
    output logic        lsu_done,
    output logic        lsu_err,
    output logic        lsu_stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);
    import lsu_pkg::*;

    // Last BUS cycle index before giving up; the counter holds cycles already waited.
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    lsu_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_f3;
    logic [1:0]       r_off;
    logic [31:0]      r_rdata;
    logic             r_done;
    logic             r_err;
    logic             r_req;
    logic             r_we;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [3:0]       r_be;

    logic [3:0]       w_be;
    logic [31:0]      w_wdata;
    logic             w_bad;
    logic [31:0]      w_ld_data;

    lsu_lane_align u_align (
        .i_funct3    (funct3),
        .i_we        (lsu_we),
        .i_off       (addr[1:0]),
        .i_wdata     (wdata),
        .i_ld_funct3 (r_f3),
        .i_ld_off    (r_off),
        .i_rdata     (mem_rdata),
        .o_be        (w_be),
        .o_wdata     (w_wdata),
        .o_bad       (w_bad),
        .o_ld_data   (w_ld_data)
    );

    // Transaction FSM with timeout counter; all bus and response outputs registered here
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_f3    <= 3'b000;
            r_off   <= 2'b00;
            r_rdata <= 32'h0000_0000;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= 32'h0000_0000;
            r_wdata <= 32'h0000_0000;
            r_be    <= 4'b0000;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (lsu_valid) begin
                        if (w_bad) begin
                            r_state <= ERR;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                            r_rdata <= 32'h0000_0000;
                        end else begin
                            r_state <= BUS;
                            r_req   <= 1'b1;
                            r_we    <= lsu_we;
                            r_addr  <= {addr[31:2], 2'b00};
                            r_wdata <= w_wdata;
                            r_be    <= w_be;
                            r_f3    <= funct3;
                            r_off   <= addr[1:0];
                            r_cnt   <= '0;
                        end
                    end else begin
                        r_state <= IDLE;
                    end
                end
                BUS: begin
                    // An ack in the final allowed cycle still wins over the timeout
                    if (mem_ack) begin
                        r_state <= RESP;
                        r_req   <= 1'b0;
                        r_done  <= 1'b1;
                        r_cnt   <= '0;
                        if (r_we) begin
                            r_rdata <= 32'h0000_0000;
                        end else begin
                            r_rdata <= w_ld_data;
                        end
                    end else if (r_cnt == TO_LAST) begin
                        r_state <= ERR;
                        r_req   <= 1'b0;
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                        r_rdata <= 32'h0000_0000;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt   <= r_cnt + CNT_W'(1);
                    end
                end
                RESP:    r_state <= IDLE;
                ERR:     r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign lsu_stall = lsu_valid & ((r_state == IDLE) | (r_state == BUS));
    assign lsu_rdata = r_rdata;
    assign lsu_done  = r_done;
    assign lsu_err   = r_err;
    assign mem_req   = r_req;
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_be    = r_be;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Randomised and directed bench for lsu_mem_ctrl against a byte-arithmetic reference model.
module tb_lsu_mem_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lsu_valid = 1'b0;
    logic        lsu_we = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] lsu_rdata;
    logic        lsu_done;
    logic        lsu_err;
    logic        lsu_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;

    int n_cmp = 0;
    int n_bad = 0;

    lsu_mem_ctrl #(.TIMEOUT(TO), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .lsu_valid(lsu_valid), .lsu_we(lsu_we), .funct3(funct3),
        .addr(addr), .wdata(wdata), .lsu_rdata(lsu_rdata), .lsu_done(lsu_done),
        .lsu_err(lsu_err), .lsu_stall(lsu_stall), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: access size in bytes from the low funct3 bits
    function automatic int nbytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit is_ok(input logic we, input logic [2:0] f3, input logic [1:0] off);
        if (f3 == 3'b011 || f3[2:1] == 2'b11) return 1'b0;
        if (f3[2] && we) return 1'b0;
        return (int'(off) % nbytes(f3)) == 0;
    endfunction

    function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [1:0] off);
        int v;
        v = ((1 << nbytes(f3)) - 1) << off;
        return v[3:0];
    endfunction

    function automatic logic [31:0] exp_wd(input logic [2:0] f3, input logic [31:0] w);
        int n;
        n = nbytes(f3);
        if (n == 1) return {24'h0, w[7:0]} * 32'h0101_0101;
        if (n == 2) return {16'h0, w[15:0]} * 32'h0001_0001;
        return w;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] rd);
        logic [31:0] v;
        int n;
        n = nbytes(f3);
        v = rd >> (8 * off);
        if (n == 1) begin
            v = v & 32'h0000_00FF;
            if (!f3[2] && v[7]) v = v | 32'hFFFF_FF00;
        end else if (n == 2) begin
            v = v & 32'h0000_FFFF;
            if (!f3[2] && v[15]) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    // One instruction; d = cycle of ack relative to issue (d > TO means no ack)
    task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input int d, input logic [31:0] rd);
        bit ok;
        int last;
        @(posedge clk); #1;
        ok = is_ok(we, f3, a[1:0]);
        lsu_valid = 1'b1; lsu_we = we; funct3 = f3; addr = a; wdata = wd;
        mem_ack = 1'b0; mem_rdata = rd;
        @(negedge clk);
        check_eq("c0_req", mem_req, 1'b0);
        check_eq("c0_stall", lsu_stall, 1'b1);
        check_eq("c0_done", lsu_done, 1'b0);
        if (!ok) begin
            @(posedge clk); #1;
            @(negedge clk);
            check_eq("bad_req", mem_req, 1'b0);
            check_eq("bad_done", lsu_done, 1'b1);
            check_eq("bad_err", lsu_err, 1'b1);
            check_eq("bad_rdata", lsu_rdata, 32'h0);
            check_eq("bad_stall", lsu_stall, 1'b0);
            return;
        end
        last = (d <= TO) ? d : TO;
        for (int k = 1; k <= last; k++) begin
            @(posedge clk); #1;
            mem_ack = (k == d);
            @(negedge clk);
            check_eq("bus_req", mem_req, 1'b1);
            check_eq("bus_we", mem_we, we);
            check_eq("bus_addr", mem_addr, {a[31:2], 2'b00});
            check_eq("bus_be", mem_be, exp_be(f3, a[1:0]));
            if (we) check_eq("bus_wdata", mem_wdata, exp_wd(f3, wd));
            check_eq("bus_stall", lsu_stall, 1'b1);
            check_eq("bus_done", lsu_done, 1'b0);
        end
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(negedge clk);
        check_eq("end_done", lsu_done, 1'b1);
        check_eq("end_err", lsu_err, (d > TO) ? 1'b1 : 1'b0);
        check_eq("end_req", mem_req, 1'b0);
        check_eq("end_stall", lsu_stall, 1'b0);
        if (d > TO) check_eq("to_rdata", lsu_rdata, 32'h0);
        else if (!we) check_eq("ld_rdata", lsu_rdata, exp_load(f3, a[1:0], rd));
    endtask

    task automatic idle(input logic ack);
        @(posedge clk); #1;
        rst = 1'b0; lsu_valid = 1'b0; mem_ack = ack;
        @(negedge clk);
        check_eq("idle_done", lsu_done, 1'b0);
        check_eq("idle_req", mem_req, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        check_eq("rst_req", mem_req, 1'b0);
        check_eq("rst_done", lsu_done, 1'b0);
        check_eq("rst_err", lsu_err, 1'b0);
        check_eq("rst_rdata", lsu_rdata, 32'h0);
        check_eq("rst_be", mem_be, 4'h0);
        check_eq("rst_addr", mem_addr, 32'h0);
        idle(1'b0);

        run_txn(1'b0, 3'b010, 32'h0000_0100, 32'h0, 1, 32'hDEAD_BEEF);
        run_txn(1'b0, 3'b000, 32'h0000_0103, 32'h0, 1, 32'h8011_2233);
        run_txn(1'b0, 3'b100, 32'h0000_0103, 32'h0, 2, 32'h8011_2233);
        run_txn(1'b0, 3'b101, 32'h0000_0102, 32'h0, 1, 32'h8011_2233);
        idle(1'b0);
        run_txn(1'b1, 3'b000, 32'h0000_0201, 32'h0000_00A5, 4, 32'h0);
        run_txn(1'b0, 3'b010, 32'h0000_1002, 32'h0, 1, 32'h0);
        run_txn(1'b0, 3'b011, 32'h0000_1000, 32'h0, 1, 32'h0);
        run_txn(1'b1, 3'b101, 32'h0000_1000, 32'h0, 1, 32'h0);
        idle(1'b0);
        run_txn(1'b0, 3'b010, 32'h0000_0040, 32'h0, TO + 5, 32'h1234_5678);
        idle(1'b1);
        idle(1'b0);

        // Reset in the middle of a bus wait
        @(posedge clk); #1;
        lsu_valid = 1'b1; lsu_we = 1'b0; funct3 = 3'b010; addr = 32'h0000_0300;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check_eq("pre_rst_req", mem_req, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0; lsu_valid = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_req", mem_req, 1'b0);
        check_eq("mid_rst_done", lsu_done, 1'b0);
        check_eq("mid_rst_be", mem_be, 4'h0);
        check_eq("mid_rst_addr", mem_addr, 32'h0);
        idle(1'b0);
        run_txn(1'b0, 3'b010, 32'h0000_0300, 32'h0, 2, 32'hCAFE_F00D);

        for (int i = 0; i < 60; i++) begin
            logic        r_we_v;
            logic [2:0]  r_f3_v;
            logic [31:0] r_a_v;
            r_we_v = 1'($urandom_range(0, 1));
            r_f3_v = 3'($urandom_range(0, 7));
            r_a_v  = $urandom;
            run_txn(r_we_v, r_f3_v, r_a_v, $urandom, $urandom_range(1, TO + 2), $urandom);
            if ($urandom_range(0, 1) == 1) idle(1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
